// File: rtl/spi_target_datapath.sv
// SPI target datapath: synchronises the external SPI pins into the clk domain, shifts bytes
// both ways on the CPOL/CPHA-selected edges and trades them with the host over valid/ready.
module spi_target_datapath #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_DEFAULT  = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              tx_underrun_o,
    output logic              rx_overrun_o,
    output logic              busy_o,
    input  logic              clr_flags_i
);
    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;

    state_e              state_q;
    logic [CntW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0]   tx_hold_q, tx_sr_q, rx_sr_q, rx_data_q;
    logic                tx_full_q, rx_valid_q, tx_underrun_q, rx_overrun_q, miso_q;

    logic                lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, last_bit;
    logic [DATA_W-1:0]   load_byte, rx_next;

    function automatic logic head(input logic [DATA_W-1:0] b, input logic lsb);
        return lsb ? b[0] : b[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] b, input logic lsb);
        return lsb ? (b >> 1) : (b << 1);
    endfunction

    // cs_n synchroniser resets deasserted so reset release never looks like a select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    always_comb begin
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        lead_edge   = (sclk_prev_q == cpol_i) && (sclk_s != cpol_i);
        trail_edge  = (sclk_prev_q != cpol_i) && (sclk_s == cpol_i);
        sample_edge = cpha_i ? trail_edge : lead_edge;
        shift_edge  = cpha_i ? lead_edge : trail_edge;
        cs_fall     = cs_prev_q && !cs_s;
        last_bit    = (bit_cnt_q == CntW'(DATA_W - 1));
        load_byte   = tx_full_q ? tx_hold_q : TX_DEFAULT;
        rx_next     = lsb_first_i ? {mosi_s, rx_sr_q[DATA_W-1:1]}
                                  : {rx_sr_q[DATA_W-2:0], mosi_s};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            tx_hold_q     <= '0;
            tx_full_q     <= 1'b0;
            tx_sr_q       <= '0;
            rx_sr_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            tx_underrun_q <= 1'b0;
            if (tx_valid_i && !tx_full_q) begin
                tx_hold_q <= tx_data_i;
                tx_full_q <= 1'b1;
            end
            if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;
            if (clr_flags_i) rx_overrun_q <= 1'b0;

            if (cs_s) begin
                state_q   <= StIdle;
                bit_cnt_q <= '0;
                miso_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: if (cs_fall) state_q <= StLoad;
                    StLoad: begin
                        if (tx_full_q) tx_full_q <= 1'b0;
                        else tx_underrun_q <= 1'b1;
                        // CPHA=0 must present bit 0 before the first edge, so consume it now
                        if (!cpha_i) begin
                            miso_q  <= head(load_byte, lsb_first_i);
                            tx_sr_q <= advance(load_byte, lsb_first_i);
                        end else begin
                            tx_sr_q <= load_byte;
                        end
                        state_q <= StShift;
                    end
                    StShift: begin
                        if (sample_edge) begin
                            rx_sr_q <= rx_next;
                            if (last_bit) begin
                                bit_cnt_q <= '0;
                                if (rx_valid_q && !rx_ready_i) begin
                                    rx_overrun_q <= 1'b1;
                                end else begin
                                    rx_data_q  <= rx_next;
                                    rx_valid_q <= 1'b1;
                                end
                                // next byte goes out unconsumed; the following shift edge shows bit 0
                                tx_sr_q <= load_byte;
                                if (tx_full_q) tx_full_q <= 1'b0;
                                else tx_underrun_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CntW'(1);
                            end
                        end else if (shift_edge) begin
                            miso_q  <= head(tx_sr_q, lsb_first_i);
                            tx_sr_q <= advance(tx_sr_q, lsb_first_i);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign miso_o        = miso_q;
    assign miso_oe_o     = (state_q != StIdle);
    assign busy_o        = (state_q != StIdle);
    assign tx_ready_o    = !tx_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_underrun_o = tx_underrun_q;
    assign rx_overrun_o  = rx_overrun_q;

endmodule

// File: tb/tb_spi_target_datapath.sv
// Bench for spi_target_datapath: plays the SPI controller, keeps a byte-level model of the
// holding register and RX handshake, and checks host-side outputs every cycle.
module tb_spi_target_datapath;
    localparam int DW   = 8;
    localparam int HALF = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sclk, cs_n, mosi, cpol, cpha, lsb;
    logic          miso, miso_oe, tx_ready, rx_valid, rx_ready;
    logic          tx_underrun, rx_overrun, busy, clr_flags, tx_valid;
    logic [DW-1:0] tx_data, rx_data;

    spi_target_datapath #(.DATA_W(DW), .SYNC_STAGES(2), .TX_DEFAULT(8'hFF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sclk_i       (sclk),
        .cs_n_i       (cs_n),
        .mosi_i       (mosi),
        .miso_o       (miso),
        .miso_oe_o    (miso_oe),
        .cpol_i       (cpol),
        .cpha_i       (cpha),
        .lsb_first_i  (lsb),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .tx_underrun_o(tx_underrun),
        .rx_overrun_o (rx_overrun),
        .busy_o       (busy),
        .clr_flags_i  (clr_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: one-entry holding buffer, bytes loaded into the shifter, RX delivery queue
    logic [DW-1:0] m_hold;
    logic          m_full, m_pending, m_overrun;
    int            m_underruns = 0;
    int            dut_underruns = 0;
    logic [DW-1:0] exp_rx[$];
    logic [DW-1:0] load_q[$];
    logic [DW-1:0] tx_m[$];
    int            refill[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] got_byte;
    logic          prev_valid = 1'b0;
    logic          prev_und = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0; m_pending = 1'b0; m_overrun = 1'b0;
        exp_rx.delete();
    endtask

    task automatic model_load();
        if (m_full) begin
            load_q.push_back(m_hold);
            m_full = 1'b0;
        end else begin
            load_q.push_back(8'hFF);
            m_underruns++;
        end
    endtask

    task automatic model_rx(input logic [DW-1:0] b);
        if (m_pending && !rx_ready) m_overrun = 1'b1;
        else begin
            exp_rx.push_back(b);
            m_pending = !rx_ready;
        end
    endtask

    initial begin : compare
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_und = 1'b0;
            end else begin
                chk("oe_vs_busy", miso_oe, busy);
                if (!miso_oe) chk("miso_when_deselected", miso, 1'b0);
                if (tx_underrun) begin
                    dut_underruns++;
                    chk("underrun_pulse_width", prev_und, 1'b0);
                end
                if (rx_valid && (!prev_valid || rx_ready)) begin
                    if (exp_rx.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rx_unexpected: got %02h, required no delivery", rx_data);
                    end else begin
                        chk("rx_data", rx_data, exp_rx.pop_front());
                    end
                end
                prev_valid = rx_valid;
                prev_und = tx_underrun;
            end
        end
    end

    task automatic write_tx(input logic [DW-1:0] b);
        @(negedge clk);
        chk("tx_ready_before_write", tx_ready, 1'b1);
        tx_data = b; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_ready_after_write", tx_ready, 1'b0);
        m_hold = b; m_full = 1'b1;
    endtask

    task automatic take_bit(input logic s, input int b, input int i);
        logic [DW-1:0] want;
        if (lsb) got_byte[i] = s;
        else got_byte[DW-1-i] = s;
        if (i == DW - 1) begin
            want = load_q[b];
            chk("miso_byte", got_byte, want);
            got_q.push_back(got_byte);
            model_rx(tx_m[b]);
            model_load();
        end
    endtask

    task automatic spi_xfer(input int nbits, input bit chk_first);
        logic [DW-1:0] cur, l0;
        logic          bitv, s;
        int            b, i, r;
        load_q.delete(); got_q.delete();
        got_byte = '0;
        sclk = cpol; mosi = 1'b0;
        repeat (4) @(negedge clk);
        cs_n = 1'b0;
        model_load();
        repeat (8) @(negedge clk);
        chk("tx_ready_after_load", tx_ready, !m_full);
        for (int n = 0; n < nbits; n++) begin
            b = n / DW; i = n % DW;
            cur = tx_m[b];
            bitv = lsb ? cur[i] : cur[DW-1-i];
            if (!cpha) mosi = bitv;
            repeat (HALF) @(negedge clk);
            if (i == 0 && b < refill.size()) begin
                r = refill[b];
                if (r >= 0) write_tx(r[DW-1:0]);
            end
            if (chk_first && n == 0) chk("cpha1_miso_before_lead", miso, 1'b0);
            s = miso;
            sclk = ~cpol;
            if (cpha) mosi = bitv;
            else take_bit(s, b, i);
            repeat (HALF) @(negedge clk);
            if (chk_first && n == 0) begin
                l0 = load_q[0];
                chk("cpha1_miso_after_lead", miso, lsb ? l0[0] : l0[DW-1]);
            end
            s = miso;
            sclk = cpol;
            if (cpha) take_bit(s, b, i);
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic end_checks();
        repeat (4) @(negedge clk);
        chk("rx_all_delivered", exp_rx.size(), 0);
        chk("underrun_count", dut_underruns, m_underruns);
        chk("rx_overrun", rx_overrun, m_overrun);
        chk("tx_ready_idle", tx_ready, !m_full);
        chk("busy_idle", busy, 1'b0);
    endtask

    task automatic reset_checks();
        chk("rst_miso", miso, 1'b0);
        chk("rst_miso_oe", miso_oe, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_underrun", tx_underrun, 1'b0);
        chk("rst_overrun", rx_overrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
    endtask

    initial begin : stim
        int und0;
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1; clr_flags = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_checks();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // mode 0, MSB first: A5 out, 3C in
        write_tx(8'hA5);
        tx_m = '{8'h3C}; refill = '{};
        spi_xfer(8, 1'b0);
        end_checks();
        chk("mode0_miso_literal", got_q[0], 8'hA5);
        chk("mode0_rx_literal", rx_data, 8'h3C);
        chk("mode0_underrun_literal", dut_underruns, 1);

        // modes 1..3, LSB first, 0x81 both ways
        for (int m = 1; m < 4; m++) begin
            cpol = m[1]; cpha = m[0]; lsb = 1'b1;
            write_tx(8'h81);
            tx_m = '{8'h81}; refill = '{};
            spi_xfer(8, m == 3);
            end_checks();
            chk("lsb_miso_literal", got_q[0], 8'h81);
            chk("lsb_rx_literal", rx_data, 8'h81);
        end

        // empty holding at select: default byte shifts out, one pulse (refill covers the reload)
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
        und0 = dut_underruns;
        tx_m = '{8'h42}; refill = '{32'h11};
        spi_xfer(8, 1'b0);
        end_checks();
        chk("underrun_miso_literal", got_q[0], 8'hFF);
        chk("underrun_pulses_literal", dut_underruns - und0, 1);

        // two bytes while host stalls: second dropped, overrun sticky until cleared
        rx_ready = 1'b0;
        write_tx(8'h12);
        tx_m = '{8'hC1, 8'hC2}; refill = '{32'h34, -1};
        spi_xfer(16, 1'b0);
        end_checks();
        chk("ovr_flag_literal", rx_overrun, 1'b1);
        chk("ovr_valid_held", rx_valid, 1'b1);
        chk("ovr_first_byte_kept", rx_data, 8'hC1);
        chk("ovr_second_miso", got_q[1], 8'h34);
        @(negedge clk); clr_flags = 1'b1;
        @(negedge clk); clr_flags = 1'b0;
        m_overrun = 1'b0;
        chk("ovr_cleared", rx_overrun, 1'b0);
        rx_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        m_pending = 1'b0;
        chk("ovr_drained", rx_valid, 1'b0);

        // deselect after 4 bits, then a clean frame
        write_tx(8'h77);
        tx_m = '{8'hF0}; refill = '{};
        spi_xfer(4, 1'b0);
        end_checks();
        chk("abort_no_valid", rx_valid, 1'b0);
        write_tx(8'h66);
        tx_m = '{8'h5A};
        spi_xfer(8, 1'b0);
        end_checks();
        chk("after_abort_rx", rx_data, 8'h5A);
        chk("after_abort_miso", got_q[0], 8'h66);

        // asynchronous reset in the middle of a frame
        write_tx(8'h55);
        cs_n = 1'b0;
        repeat (10) @(negedge clk);
        sclk = 1'b1; mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks();
        cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        write_tx(8'hC3);
        tx_m = '{8'h96}; refill = '{};
        spi_xfer(8, 1'b0);
        end_checks();
        chk("post_reset_rx", rx_data, 8'h96);
        chk("post_reset_miso", got_q[0], 8'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
